// File: rtl/gray_ptr_receiver.sv
// rtl/gray_ptr_receiver.sv - receives a Gray pointer from a foreign clock domain
// and derives the registered occupancy, empty/full, threshold and protocol-error flags.
module gray_ptr_receiver #(
  parameter int D_WIDTH     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int THRESH      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH:0]   local_ptr,
  input  logic [D_WIDTH:0]   remote_ptr,
  output logic [D_WIDTH:0]   remote_bin,
  output logic [D_WIDTH:0]   level,
  output logic               flag,
  output logic               thresh_flag,
  output logic               err
);

  localparam int PW    = D_WIDTH + 1;
  localparam int DEPTH = 1 << D_WIDTH;

  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] THR_LO   = PW'(THRESH);
  localparam logic [PW-1:0] THR_HI   = PW'(DEPTH - THRESH);
  localparam logic          FLAG_RST = (MODE == 0);
  localparam logic          THR_RST  = (MODE == 0) || (THRESH >= DEPTH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [PW-1:0] level_q, level_d;
  logic          flag_q, flag_d;
  logic          thr_q, thr_d;
  logic          err_q, err_d;

  logic [PW-1:0] remote_bin_c;
  logic [PW-1:0] local_bin;
  logic [PW-1:0] diff;
  logic [PW-1:0] chg;

  always_comb begin
    // Plain shift chain: stage 0 samples the asynchronous input, nothing sits between stages.
    sync_d       = {sync_q[SYNC_STAGES-2:0], remote_ptr};
    hist_d       = sync_q[SYNC_STAGES-1];
    remote_bin_c = gray2bin(sync_q[SYNC_STAGES-1]);
    local_bin    = gray2bin(local_ptr);

    if (MODE == 0) begin
      diff   = remote_bin_c - local_bin;
      flag_d = (diff == '0);
      thr_d  = (diff <= THR_LO);
    end else begin
      diff   = local_bin - remote_bin_c;
      flag_d = (diff == DEPTH_V);
      thr_d  = (diff >= THR_HI);
    end
    level_d = diff;

    // A legal Gray sequence changes at most one bit per sampled step.
    chg   = sync_q[SYNC_STAGES-1] ^ hist_q;
    err_d = err_q | ((chg & (chg - PW'(1))) != '0) | (diff > DEPTH_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= '0;
      flag_q  <= FLAG_RST;
      thr_q   <= THR_RST;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      flag_q  <= flag_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
    end
  end

  assign remote_bin  = remote_bin_c;
  assign level       = level_q;
  assign flag        = flag_q;
  assign thresh_flag = thr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// tb/tb_gray_ptr_receiver.sv - self-checking bench for gray_ptr_receiver, read side and write side
// instances side by side.
module tb_gray_ptr_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] l0, r0, l1, r1;
  logic [4:0] rb0, lv0, rb1, lv1;
  logic       f0, t0, e0, f1, t1, e1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_ptr_receiver #(.D_WIDTH(4), .SYNC_STAGES(2), .MODE(0), .THRESH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .local_ptr(l0), .remote_ptr(r0),
    .remote_bin(rb0), .level(lv0), .flag(f0), .thresh_flag(t0), .err(e0)
  );

  gray_ptr_receiver #(.D_WIDTH(4), .SYNC_STAGES(2), .MODE(1), .THRESH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .local_ptr(l1), .remote_ptr(r1),
    .remote_bin(rb1), .level(lv1), .flag(f1), .thresh_flag(t1), .err(e1)
  );

  typedef struct {
    int mode;
    int lb;
    int rb;
    int lvl;
    int fl;
    int th;
  } vec_t;

  vec_t vt[10];

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int a0, b0, a1, b1, e0m, e1m;
    int q0[$];
    int q1[$];

    rst_n = 1'b1;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    #2;
    rst_n = 1'b0;
    #2;
    chk("rst_level0", int'(lv0), 0);
    chk("rst_flag0", int'(f0), 1);
    chk("rst_thr0", int'(t0), 1);
    chk("rst_err0", int'(e0), 0);
    chk("rst_level1", int'(lv1), 0);
    chk("rst_flag1", int'(f1), 0);
    chk("rst_thr1", int'(t1), 0);
    chk("rst_err1", int'(e1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Static vectors: binary pointer values, expected level / flag / thresh_flag.
    vt[0] = '{0,  0,  0,  0, 1, 1};
    vt[1] = '{0,  3,  5,  2, 0, 1};
    vt[2] = '{0,  3,  6,  3, 0, 0};
    vt[3] = '{0, 30,  4,  6, 0, 0};
    vt[4] = '{0, 10, 26, 16, 0, 0};
    vt[5] = '{1, 16,  0, 16, 1, 1};
    vt[6] = '{1, 20,  7, 13, 0, 0};
    vt[7] = '{1, 20,  6, 14, 0, 1};
    vt[8] = '{1,  2, 20, 14, 0, 1};
    vt[9] = '{1,  5,  5,  0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].mode == 0) begin
        l0 = g(vt[i].lb); r0 = g(vt[i].rb);
      end else begin
        l1 = g(vt[i].lb); r1 = g(vt[i].rb);
      end
      step(4);
      if (vt[i].mode == 0) begin
        chk("vec_rbin0", int'(rb0), vt[i].rb);
        chk("vec_level0", int'(lv0), vt[i].lvl);
        chk("vec_flag0", int'(f0), vt[i].fl);
        chk("vec_thr0", int'(t0), vt[i].th);
      end else begin
        chk("vec_rbin1", int'(rb1), vt[i].rb);
        chk("vec_level1", int'(lv1), vt[i].lvl);
        chk("vec_flag1", int'(f1), vt[i].fl);
        chk("vec_thr1", int'(t1), vt[i].th);
      end
    end

    // Single-step latency in both modes.
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    do_reset();
    r0 = g(1);
    l1 = 5'b11000;
    step(1);
    chk("lat_rbin0_e1", int'(rb0), 0);
    chk("lat_level1_e1", int'(lv1), 16);
    chk("lat_flag1_e1", int'(f1), 1);
    chk("lat_thr1_e1", int'(t1), 1);
    step(1);
    chk("lat_rbin0_e2", int'(rb0), 1);
    chk("lat_level0_e2", int'(lv0), 0);
    chk("lat_flag0_e2", int'(f0), 1);
    step(1);
    chk("lat_level0_e3", int'(lv0), 1);
    chk("lat_flag0_e3", int'(f0), 0);
    chk("lat_thr0_e3", int'(t0), 1);
    r1 = g(1);
    step(3);
    chk("lat_rbin1", int'(rb1), 1);
    chk("lat_level1", int'(lv1), 15);
    chk("lat_flag1", int'(f1), 0);
    chk("lat_thr1", int'(t1), 1);

    // Two-bit jump on the remote pointer.
    l0 = '0; r0 = '0;
    do_reset();
    r0 = 5'b00011;
    step(2);
    chk("jump_err_e2", int'(e0), 0);
    step(1);
    chk("jump_err_e3", int'(e0), 1);
    chk("jump_level", int'(lv0), 2);
    r0 = 5'b00010;
    step(3);
    chk("jump_level_track", int'(lv0), 3);
    chk("jump_err_sticky", int'(e0), 1);
    rst_n = 1'b0;
    #2;
    chk("jump_err_cleared", int'(e0), 0);
    r0 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset mid-stream at level 5, then in-flight data discarded.
    for (int k = 1; k <= 5; k++) begin
      r0 = g(k);
      step(3);
    end
    step(1);
    chk("mid_level_before", int'(lv0), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_level0", int'(lv0), 0);
    chk("mid_flag0", int'(f0), 1);
    chk("mid_thr0", int'(t0), 1);
    chk("mid_err0", int'(e0), 0);
    chk("mid_level1", int'(lv1), 0);
    chk("mid_flag1", int'(f1), 0);
    chk("mid_thr1", int'(t1), 0);
    r0 = g(5);
    l0 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    chk("post_rst_level_e2", int'(lv0), 0);
    step(1);
    chk("post_rst_level_e3", int'(lv0), 5);

    // Wrap-around across the pointer MSB boundary.
    l0 = '0; r0 = '0;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      r0 = g(k);
      step(3);
      l0 = g(k);
      step(1);
    end
    step(3);
    chk("wrap_level_30", int'(lv0), 0);
    r0 = g(31);
    step(3);
    chk("wrap_level_31", int'(lv0), 1);
    r0 = g(0);
    step(3);
    chk("wrap_level_0", int'(lv0), 2);
    r0 = g(1);
    step(3);
    chk("wrap_level_1", int'(lv0), 3);
    chk("wrap_err", int'(e0), 0);

    // Random legal pointer walks compared against a delayed-difference model.
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    do_reset();
    step(3);
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    q0 = {0, 0};
    q1 = {0, 0};
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 1 && ((a0 - b0) & 31) < 16) a0 = (a0 + 1) & 31;
      if ($urandom_range(0, 1) == 1 && ((q0[$-1] - b0) & 31) > 0) b0 = (b0 + 1) & 31;
      if ($urandom_range(0, 1) == 1 && ((b1 - q1[$-1]) & 31) < 16) b1 = (b1 + 1) & 31;
      if ($urandom_range(0, 1) == 1 && ((b1 - a1) & 31) > 0) a1 = (a1 + 1) & 31;
      l0 = g(b0); r0 = g(a0);
      l1 = g(b1); r1 = g(a1);
      q0.push_back(a0);
      q1.push_back(a1);
      step(1);
      e0m = (q0[$-2] - b0) & 31;
      e1m = (b1 - q1[$-2]) & 31;
      chk("rnd_rbin0", int'(rb0), q0[$-1]);
      chk("rnd_level0", int'(lv0), e0m);
      chk("rnd_flag0", int'(f0), int'(e0m == 0));
      chk("rnd_thr0", int'(t0), int'(e0m <= 2));
      chk("rnd_err0", int'(e0), 0);
      chk("rnd_rbin1", int'(rb1), q1[$-1]);
      chk("rnd_level1", int'(lv1), e1m);
      chk("rnd_flag1", int'(f1), int'(e1m == 16));
      chk("rnd_thr1", int'(t1), int'(e1m >= 14));
      chk("rnd_err1", int'(e1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_ptr_receiver.md
GRAY_PTR_RECEIVER -- requirements
Module: gray_ptr_receiver

Interface
REQ-001 Parameter D_WIDTH, default 8, address width; pointers are D_WIDTH+1 bits and DEPTH = 2^D_WIDTH.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, number of synchronizer flops on remote_ptr.
REQ-003 Parameter MODE, default 0; 0 = read side (remote is write pointer), 1 = write side (remote is read pointer).
REQ-004 Parameter THRESH, default 2, almost-threshold in entries, range 0..DEPTH.
REQ-005 clk  input  1  sole clock; all flops rise on posedge clk.
REQ-006 rst_n  input  1  asynchronous active-low reset, asserted without clk, released synchronously by the system.
REQ-007 local_ptr  input  D_WIDTH+1  Gray pointer of the local-domain counter, already in clk domain.
REQ-008 remote_ptr  input  D_WIDTH+1  Gray pointer from the opposite clock domain, asynchronous to clk.
REQ-009 remote_bin  output  D_WIDTH+1  binary decode of the synchronized remote pointer.
REQ-010 level  output  D_WIDTH+1  registered occupancy: MODE 0 = entries readable, MODE 1 = entries written.
REQ-011 flag  output  1  registered empty (MODE 0) or full (MODE 1).
REQ-012 thresh_flag  output  1  registered almost_empty (MODE 0) or almost_full (MODE 1).
REQ-013 err  output  1  sticky protocol-error indication.

Function
REQ-014 remote_ptr SHALL pass through SYNC_STAGES flops; no logic between stages; only the last stage is used.
REQ-015 A history register SHALL hold the previous last-stage value, updated every cycle.
REQ-016 Gray-to-binary: bin[D_WIDTH] = g[D_WIDTH]; bin[i] = bin[i+1] XOR g[i] for i below D_WIDTH; applied to the last sync stage (remote_bin) and to local_ptr.
REQ-017 remote_bin SHALL be combinational from the last sync stage: a remote change is visible SYNC_STAGES edges after it becomes stable at the flop input.
REQ-018 Difference arithmetic SHALL be modulo 2^(D_WIDTH+1): MODE 0 diff = remote_bin - local_bin; MODE 1 diff = local_bin - remote_bin.
REQ-019 level SHALL register diff every cycle: one cycle after local_ptr changes and SYNC_STAGES+1 cycles after remote_ptr changes.
REQ-020 MODE 0: flag SHALL register (diff == 0), and thresh_flag SHALL register (diff <= THRESH).
REQ-021 MODE 1: flag SHALL register (diff == DEPTH), i.e. MSB differs and the lower bits match, and thresh_flag SHALL register (diff >= DEPTH-THRESH).
REQ-022 flag, thresh_flag and level SHALL update in the same cycle from the same diff; there SHALL be no one-cycle skew between them.
REQ-023 Wrap-around: a pointer crossing from 2^(D_WIDTH+1)-1 to 0 SHALL give a continuous level with no glitch.
REQ-024 Simultaneous local and remote changes in one cycle SHALL be handled by the single diff of REQ-018, with no priority logic.
REQ-025 err SHALL set when the last sync stage differs from the history register in more than one bit.
REQ-026 err SHALL also set when diff > DEPTH.
REQ-027 Once set, err SHALL stay high until rst_n is asserted; err SHALL NOT alter level or flags.
REQ-028 The block SHALL hold no state beyond the sync chain, history register, level, flag, thresh_flag and err.

Reset
REQ-029 On rst_n low, the following SHALL clear to 0 immediately: all sync stages, the history register, level and err.
REQ-030 MODE 0 reset values: flag = 1 and thresh_flag = 1.
REQ-031 MODE 1 reset values: flag = 0, and thresh_flag = 1 only if THRESH >= DEPTH, else 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight sync data; after release the first level SHALL reflect inputs sampled after release.

Verification (D_WIDTH=4, DEPTH=16, SYNC_STAGES=2, THRESH=2)
REQ-033 MODE 0, reset, local_ptr=0, remote_ptr steps Gray 0->1 -> remote_bin=1 after 2 edges; level=1, flag 1->0 and thresh_flag still 1 after 3 edges.
REQ-034 MODE 1, local_ptr=Gray(16)=5'b11000, remote_ptr=0 -> after 1 edge level=16, flag=1 and thresh_flag=1; then remote_ptr=Gray(1) -> after 3 edges level=15, flag=0 and thresh_flag=1.
REQ-035 MODE 0 wrap: local=Gray(30), remote steps Gray(30)->Gray(31)->Gray(0)->Gray(1) -> level sequence 0,1,2,3 and err=0.
REQ-036 remote_ptr jumps 5'b00000->5'b00011 (2 bits) -> err=1 three edges later and stays 1; level keeps tracking; rst_n pulse clears err to 0.
REQ-037 Reset mid-stream with level=5: rst_n low without clk -> level=0, flag at its reset value and err=0 immediately.
REQ-038 Random independent pointer walks in both modes -> level always equals the binary difference delayed per REQ-019, and err stays 0.
